// File: rtl/fetch_pc_unit.sv
// ============================================================================
// Module   : fetch_pc_unit
// Brief    : NeoCore fetch front end. Owns the fetch PC, issues one word
//            request at a time and presents fetched words to decode.
//            Optional NEOCORE_FETCH_PERF_EN adds fetch/redirect counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FETCH_STRIDE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_data,
  input  logic        fetch_ready
`ifdef NEOCORE_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_count,
  output logic [31:0] perf_redirect_count
`endif
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [31:0] STRIDE = 32'(FETCH_STRIDE);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] fetch_pc_q;
  logic [31:0] fetch_data_q;
  logic        capture;
  logic        req_fire;

  assign req_fire = (state_q == S_REQ) && imem_req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // A redirect always wins; the only question is whether a request is still
  // owed a response that must be swallowed (DRAIN) or not (REQ).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    capture = 1'b0;
    case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = req_fire ? S_DRAIN : S_REQ;
        end else if (req_fire) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
        end else if (imem_rsp_valid) begin
          capture = 1'b1;
          pc_d    = pc_q + STRIDE;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (fetch_ready) begin
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end
        if (imem_rsp_valid) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q   <= 32'h0;
      fetch_data_q <= 32'h0;
    end else if (capture) begin
      fetch_pc_q   <= pc_q;
      fetch_data_q <= imem_rsp_data;
    end
  end

  assign imem_req_valid = (state_q == S_REQ) && !rst;
  assign imem_req_addr  = pc_q;
  assign fetch_valid    = (state_q == S_HOLD);
  assign fetch_pc       = fetch_pc_q;
  assign fetch_data     = fetch_data_q;

`ifdef NEOCORE_FETCH_PERF_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_redirect_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q    <= 32'h0;
      perf_redirect_q <= 32'h0;
    end else begin
      if (fetch_valid && fetch_ready) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (redirect_valid) begin
        perf_redirect_q <= perf_redirect_q + 32'd1;
      end
    end
  end

  assign perf_fetch_count    = perf_fetch_q;
  assign perf_redirect_count = perf_redirect_q;
`else
  // Counters absent in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
// ============================================================================
// Module   : tb_fetch_pc_unit
// Brief    : Directed and randomized bench for fetch_pc_unit against a
//            transaction-level model of the fetch front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_pc_unit;

  localparam logic [31:0] RPC    = 32'h0000_1000;
  localparam logic [31:0] STRIDE = 32'd4;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_data;
  logic        fetch_ready;
`ifdef NEOCORE_FETCH_PERF_EN
  logic [31:0] perf_fetch_count;
  logic [31:0] perf_redirect_count;
`endif

  fetch_pc_unit #(.RESET_PC(RPC), .FETCH_STRIDE(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .fetch_data     (fetch_data),
    .fetch_ready    (fetch_ready)
`ifdef NEOCORE_FETCH_PERF_EN
    ,
    .perf_fetch_count    (perf_fetch_count),
    .perf_redirect_count (perf_redirect_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Stimulus knobs applied on the next tick
  logic        k_rst, k_rv, k_ready, k_frdy;
  logic [31:0] k_rpc;
  int          k_delay;

  // Transaction-level model: a request is either unsent, outstanding
  // (possibly already known to be wrong-path), or a word is held for decode.
  logic [31:0] m_pc, h_pc, h_data;
  bit          m_out, m_wrong, m_held;
  logic [31:0] m_perf_f, m_perf_r;

  // Instruction memory model
  bit          mem_busy;
  int          mem_delay;
  logic [31:0] mem_data;

  logic [31:0] acc_addr[$];
  int          acc_cyc[$];
  logic [31:0] pres_pc[$];
  int          pres_cyc[$];
  int          rsp_cyc;
  int          rsp_in_rst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare();
    check("req_valid", {31'b0, imem_req_valid}, {31'b0, (!rst && !m_out && !m_held)});
    check("req_addr", imem_req_addr, m_pc);
    check("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_held});
    if (m_held) begin
      check("fetch_pc", fetch_pc, h_pc);
      check("fetch_data", fetch_data, h_data);
    end
`ifdef NEOCORE_FETCH_PERF_EN
    check("perf_fetch", perf_fetch_count, m_perf_f);
    check("perf_redirect", perf_redirect_count, m_perf_r);
`endif
  endtask

  task automatic model_update();
    bit          accept;
    logic [31:0] npc;
    accept = 1'b0;
    if (rst) begin
      m_pc = RPC; m_out = 0; m_wrong = 0; m_held = 0;
      m_perf_f = 0; m_perf_r = 0;
    end else begin
      accept = !m_out && !m_held && imem_req_ready;
      npc = m_pc;
      if (m_held) begin
        if (fetch_ready) begin
          m_perf_f++;
          pres_pc.push_back(h_pc);
          pres_cyc.push_back(cyc);
        end
        if (fetch_ready || redirect_valid) m_held = 0;
      end
      if (m_out && imem_rsp_valid) begin
        if (!m_wrong && !redirect_valid) begin
          m_held = 1; h_pc = m_pc; h_data = imem_rsp_data; npc = m_pc + STRIDE;
        end
        m_out = 0;
      end else if (m_out && redirect_valid) begin
        m_wrong = 1;
      end
      if (accept) begin
        m_out = 1; m_wrong = redirect_valid;
        acc_addr.push_back(m_pc);
        acc_cyc.push_back(cyc);
      end
      if (redirect_valid) begin
        npc = redirect_pc;
        m_perf_r++;
      end
      m_pc = npc;
    end
    if (imem_rsp_valid) begin
      mem_busy = 0; rsp_cyc = cyc;
      if (rst) rsp_in_rst++;
    end else if (mem_busy) begin
      mem_delay--;
    end
    if (accept) begin
      mem_busy = 1; mem_delay = k_delay; mem_data = $urandom;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    rst            = k_rst;
    redirect_valid = k_rv;
    redirect_pc    = k_rpc;
    imem_req_ready = k_ready;
    fetch_ready    = k_frdy;
    imem_rsp_valid = mem_busy && (mem_delay == 0);
    imem_rsp_data  = imem_rsp_valid ? mem_data : $urandom;
    @(posedge clk);
    cyc++;
    model_update();
  endtask

  task automatic clear_logs();
    acc_addr.delete(); acc_cyc.delete(); pres_pc.delete(); pres_cyc.delete();
  endtask

  task automatic do_reset();
    k_rst = 1; k_rv = 0; k_ready = 0; k_frdy = 0; k_delay = 0; k_rpc = 0;
    repeat (2) tick();
    clear_logs();
  endtask

  initial begin
    rst = 1; redirect_valid = 0; redirect_pc = 0; imem_req_ready = 0;
    imem_rsp_valid = 0; imem_rsp_data = 0; fetch_ready = 0;
    m_pc = RPC; m_out = 0; m_wrong = 0; m_held = 0; h_pc = 0; h_data = 0;
    m_perf_f = 0; m_perf_r = 0; mem_busy = 0; mem_delay = 0; mem_data = 0;
    rsp_cyc = 0; rsp_in_rst = 0;

    // T1: reset values, then zero-wait streaming at one word per 3 cycles
    do_reset();
    #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0000_1000);
    check("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    check("rst_fetch_pc", fetch_pc, 32'd0);
    check("rst_fetch_data", fetch_data, 32'd0);
    k_rst = 0; k_ready = 1; k_frdy = 1; k_delay = 0;
    repeat (9) tick();
    check("t1_nacc", acc_addr.size(), 32'd3);
    check("t1_npres", pres_pc.size(), 32'd3);
    if (acc_addr.size() >= 3 && pres_pc.size() >= 3) begin
      check("t1_acc0", acc_addr[0], 32'h0000_1000);
      check("t1_acc1", acc_addr[1], 32'h0000_1004);
      check("t1_acc2", acc_addr[2], 32'h0000_1008);
      check("t1_pres0", pres_pc[0], 32'h0000_1000);
      check("t1_pres2", pres_pc[2], 32'h0000_1008);
      check("t1_spacing", 32'(pres_cyc[2] - pres_cyc[1]), 32'd3);
    end

    // T2: request held off for 5 cycles, accepted on the 6th exactly once
    do_reset();
    k_rst = 0; k_ready = 0; k_frdy = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      check("t2_valid_held", {31'b0, imem_req_valid}, 32'd1);
      check("t2_addr_held", imem_req_addr, 32'h0000_1000);
    end
    k_ready = 1;
    tick();
    k_ready = 0;
    repeat (3) tick();
    check("t2_nacc", acc_addr.size(), 32'd1);
    if (acc_addr.size() >= 1) check("t2_acc0", acc_addr[0], 32'h0000_1000);

    // T3: redirect in WAIT; response 2 cycles later is drained
    do_reset();
    k_rst = 0; k_ready = 1; k_frdy = 1; k_delay = 2;
    tick();
    k_rv = 1; k_rpc = 32'h0000_2000;
    tick();
    k_rv = 0;
    repeat (3) tick();
    check("t3_npres", pres_pc.size(), 32'd0);
    check("t3_nacc", acc_addr.size(), 32'd2);
    if (acc_addr.size() >= 2) begin
      check("t3_acc1", acc_addr[1], 32'h0000_2000);
      check("t3_acc_after_drain", 32'(acc_cyc[1] - rsp_cyc), 32'd1);
    end

    // T4: redirect while holding a word with decode stalled
    do_reset();
    k_rst = 0; k_ready = 1; k_frdy = 0; k_delay = 0;
    begin
      int n;
      n = 0;
      while (!m_held && n < 20) begin tick(); n++; end
      check("t4_hold_reached", {31'b0, m_held}, 32'd1);
    end
    k_rv = 1; k_rpc = 32'h0000_3000; k_ready = 0;
    tick();
    k_rv = 0;
    tick();
    #1;
    check("t4_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("t4_req_addr", imem_req_addr, 32'h0000_3000);
    check("t4_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    check("t4_npres", pres_pc.size(), 32'd0);

    // T5: PC wraps past the top of the address space
    do_reset();
    k_rst = 0; k_ready = 0; k_frdy = 1; k_rv = 1; k_rpc = 32'hFFFF_FFFC;
    tick();
    k_rv = 0; k_ready = 1;
    repeat (6) tick();
    check("t5_nacc", 32'(acc_addr.size() >= 2), 32'd1);
    check("t5_npres", 32'(pres_pc.size() >= 2), 32'd1);
    if (acc_addr.size() >= 2 && pres_pc.size() >= 2) begin
      check("t5_acc0", acc_addr[0], 32'hFFFF_FFFC);
      check("t5_acc1", acc_addr[1], 32'h0000_0000);
      check("t5_pres0", pres_pc[0], 32'hFFFF_FFFC);
      check("t5_pres1", pres_pc[1], 32'h0000_0000);
    end

    // T6: reset mid-WAIT with the response landing during reset
    do_reset();
    k_rst = 0; k_ready = 1; k_frdy = 1; k_delay = 3;
    rsp_in_rst = 0;
    repeat (2) tick();
    k_rst = 1;
    repeat (5) tick();
    check("t6_rsp_in_rst", 32'(rsp_in_rst), 32'd1);
    clear_logs();
    k_rst = 0; k_delay = 0;
    tick();
    #1;
    check("t6_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    check("t6_nacc", acc_addr.size(), 32'd1);
    if (acc_addr.size() >= 1) check("t6_acc0", acc_addr[0], 32'h0000_1000);
`ifdef NEOCORE_FETCH_PERF_EN
    check("t6_perf_fetch", perf_fetch_count, 32'd0);
    check("t6_perf_redirect", perf_redirect_count, 32'd0);
`endif

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      k_ready = ($urandom % 4) != 0;
      k_frdy  = ($urandom % 3) != 0;
      k_delay = int'($urandom % 4);
      k_rv    = ($urandom % 8) == 0;
      case ($urandom % 3)
        0: k_rpc = $urandom;
        1: k_rpc = 32'hFFFF_FFFC;
        default: k_rpc = $urandom & 32'h0000_FFFC;
      endcase
      if (($urandom % 400) == 0) begin
        k_rst = 1;
        repeat (5) tick();
        k_rst = 0;
      end else begin
        tick();
      end
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
